// File: rtl/regfile_wb_if.sv
// Writeback-stage and decode read-port bundle for the architectural register file.
// The pipeline side is the master; the register file is the slave.
interface regfile_wb_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic              regwriteW;
  logic              memtoregW;
  logic [AW-1:0]     writeregW;
  logic [DATA_W-1:0] aluoutW;
  logic [DATA_W-1:0] readdataW;
  logic [AW-1:0]     ra1D;
  logic [AW-1:0]     ra2D;
  logic [DATA_W-1:0] rd1D;
  logic [DATA_W-1:0] rd2D;
  logic [DATA_W-1:0] resultW;

  modport master (
    output regwriteW, memtoregW, writeregW, aluoutW, readdataW, ra1D, ra2D,
    input  rd1D, rd2D, resultW
  );

  modport slave (
    input  regwriteW, memtoregW, writeregW, aluoutW, readdataW, ra1D, ra2D,
    output rd1D, rd2D, resultW
  );
endinterface

// File: rtl/regfile_wb.sv
// MIPS architectural register file at the MEM/WB boundary: result select, posedge
// commit, r0 hardwired to zero, and same-cycle write-to-read bypass on both read ports.
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input logic         clk,
  input logic         reset,
  regfile_wb_if.slave wb
);
  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] result;
  logic              we_eff;

  assign result     = wb.memtoregW ? wb.readdataW : wb.aluoutW;
  assign wb.resultW = result;

  // Reset gates the enable so the bypass is suppressed while the array is being cleared.
  assign we_eff = wb.regwriteW && (wb.writeregW != '0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we_eff) begin
      regs[wb.writeregW] <= result;
    end
  end

  always_comb begin
    wb.rd1D = '0;
    if (wb.ra1D != '0) begin
      if (we_eff && (wb.ra1D == wb.writeregW)) begin
        wb.rd1D = result;
      end else begin
        wb.rd1D = regs[wb.ra1D];
      end
    end
  end

  always_comb begin
    wb.rd2D = '0;
    if (wb.ra2D != '0) begin
      if (we_eff && (wb.ra2D == wb.writeregW)) begin
        wb.rd2D = result;
      end else begin
        wb.rd2D = regs[wb.ra2D];
      end
    end
  end

  logic [AW-1:0] unused_aw;
  assign unused_aw = '0;
endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb: reset, bypass, load select, r0, dual port.
module tb_regfile_wb;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  regfile_wb_if #(.DATA_W(32), .AW(5)) bus ();

  regfile_wb #(.DATA_W(32), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on negedge; one commit per posedge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.regwriteW = 1'b1;
    bus.memtoregW = 1'b0;
    bus.writeregW = a;
    bus.aluoutW   = d;
    @(posedge clk);
    #1 bus.regwriteW = 1'b0;
  endtask

  task automatic test_reset;
    wr(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    bus.ra1D = 5'd5;
    #1;
    total++;
    if (bus.rd1D !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL preload_r5 got=%h exp=%h", bus.rd1D, 32'hDEADBEEF);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.rd1D !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL reset_pre_edge got=%h exp=%h", bus.rd1D, 32'hDEADBEEF);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    total++;
    if (bus.rd1D !== 32'h0) begin
      bad++;
      $display("FAIL reset_r5 got=%h exp=%h", bus.rd1D, 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      bus.ra1D = i[4:0];
      bus.ra2D = 5'(31 - i);
      #1;
      total++;
      if (bus.rd1D !== 32'h0 || bus.rd2D !== 32'h0) begin
        bad++;
        $display("FAIL reset_all addr=%0d rd1=%h rd2=%h exp=0", i, bus.rd1D, bus.rd2D);
      end
    end
  endtask

  task automatic test_write_read;
    @(negedge clk);
    bus.regwriteW = 1'b1;
    bus.memtoregW = 1'b0;
    bus.writeregW = 5'd8;
    bus.aluoutW   = 32'h12345678;
    bus.readdataW = 32'h0BADF00D;
    bus.ra1D      = 5'd8;
    #1;
    total++;
    if (bus.rd1D !== 32'h12345678) begin
      bad++;
      $display("FAIL wr_bypass got=%h exp=%h", bus.rd1D, 32'h12345678);
    end
    total++;
    if (bus.resultW !== 32'h12345678) begin
      bad++;
      $display("FAIL wr_result_alu got=%h exp=%h", bus.resultW, 32'h12345678);
    end
    @(posedge clk);
    #1 bus.regwriteW = 1'b0;
    bus.aluoutW = 32'h0;
    #1;
    total++;
    if (bus.rd1D !== 32'h12345678) begin
      bad++;
      $display("FAIL wr_array got=%h exp=%h", bus.rd1D, 32'h12345678);
    end
  endtask

  task automatic test_load_path;
    @(negedge clk);
    bus.regwriteW = 1'b1;
    bus.memtoregW = 1'b1;
    bus.writeregW = 5'd9;
    bus.aluoutW   = 32'h11111111;
    bus.readdataW = 32'hCAFEF00D;
    bus.ra1D      = 5'd9;
    bus.ra2D      = 5'd8;
    #1;
    total++;
    if (bus.resultW !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL load_result got=%h exp=%h", bus.resultW, 32'hCAFEF00D);
    end
    total++;
    if (bus.rd1D !== 32'hCAFEF00D || bus.rd2D !== 32'h12345678) begin
      bad++;
      $display("FAIL load_bypass rd1=%h rd2=%h exp=%h/%h", bus.rd1D, bus.rd2D, 32'hCAFEF00D, 32'h12345678);
    end
    @(posedge clk);
    #1 bus.regwriteW = 1'b0;
    bus.memtoregW = 1'b0;
    bus.readdataW = 32'h0;
    bus.ra2D      = 5'd9;
    #1;
    total++;
    if (bus.rd2D !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL load_array got=%h exp=%h", bus.rd2D, 32'hCAFEF00D);
    end
    total++;
    if (bus.resultW !== 32'h11111111) begin
      bad++;
      $display("FAIL result_no_we got=%h exp=%h", bus.resultW, 32'h11111111);
    end
  endtask

  task automatic test_r0;
    @(negedge clk);
    bus.regwriteW = 1'b1;
    bus.memtoregW = 1'b0;
    bus.writeregW = 5'd0;
    bus.aluoutW   = 32'hFFFFFFFF;
    bus.ra1D      = 5'd0;
    bus.ra2D      = 5'd0;
    #1;
    total++;
    if (bus.rd1D !== 32'h0 || bus.rd2D !== 32'h0) begin
      bad++;
      $display("FAIL r0_same_cycle rd1=%h rd2=%h exp=0", bus.rd1D, bus.rd2D);
    end
    @(posedge clk);
    #1 bus.regwriteW = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.rd1D !== 32'h0 || bus.rd2D !== 32'h0) begin
      bad++;
      $display("FAIL r0_later rd1=%h rd2=%h exp=0", bus.rd1D, bus.rd2D);
    end
  endtask

  task automatic test_dual_port;
    wr(5'd3, 32'hA);
    wr(5'd4, 32'hB);
    @(negedge clk);
    bus.ra1D = 5'd3;
    bus.ra2D = 5'd4;
    #1;
    total++;
    if (bus.rd1D !== 32'hA || bus.rd2D !== 32'hB) begin
      bad++;
      $display("FAIL dual_read rd1=%h rd2=%h exp=a/b", bus.rd1D, bus.rd2D);
    end
    bus.regwriteW = 1'b0;
    bus.writeregW = 5'd3;
    bus.aluoutW   = 32'h99;
    #1;
    total++;
    if (bus.rd1D !== 32'hA) begin
      bad++;
      $display("FAIL we0_no_bypass got=%h exp=%h", bus.rd1D, 32'hA);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.rd1D !== 32'hA) begin
      bad++;
      $display("FAIL we0_no_write got=%h exp=%h", bus.rd1D, 32'hA);
    end
  endtask

  task automatic test_reset_beats_write;
    wr(5'd7, 32'h77);
    @(negedge clk);
    reset         = 1'b1;
    bus.regwriteW = 1'b1;
    bus.memtoregW = 1'b0;
    bus.writeregW = 5'd7;
    bus.aluoutW   = 32'h55;
    bus.ra1D      = 5'd7;
    #1;
    total++;
    if (bus.rd1D !== 32'h77) begin
      bad++;
      $display("FAIL rst_bypass_off got=%h exp=%h", bus.rd1D, 32'h77);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    bus.regwriteW = 1'b0;
    #1;
    total++;
    if (bus.rd1D !== 32'h0) begin
      bad++;
      $display("FAIL rst_beats_wr got=%h exp=%h", bus.rd1D, 32'h0);
    end
    bus.ra2D = 5'd3;
    #1;
    total++;
    if (bus.rd2D !== 32'h0) begin
      bad++;
      $display("FAIL rst_clears_r3 got=%h exp=%h", bus.rd2D, 32'h0);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [3];
    vals[0] = 32'h1;
    vals[1] = 32'h2;
    vals[2] = 32'h3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.regwriteW = 1'b1;
      bus.memtoregW = 1'b0;
      bus.writeregW = 5'd10;
      bus.aluoutW   = vals[i];
      bus.ra1D      = 5'd10;
      bus.ra2D      = 5'd10;
      #1;
      total++;
      if (bus.rd1D !== vals[i] || bus.rd2D !== vals[i]) begin
        bad++;
        $display("FAIL b2b_bypass i=%0d rd1=%h rd2=%h exp=%h", i, bus.rd1D, bus.rd2D, vals[i]);
      end
    end
    @(posedge clk);
    #1 bus.regwriteW = 1'b0;
    bus.ra2D = 5'd11;
    #1;
    total++;
    if (bus.rd1D !== 32'h3 || bus.rd2D !== 32'h0) begin
      bad++;
      $display("FAIL b2b_last rd1=%h rd2=%h exp=3/0", bus.rd1D, bus.rd2D);
    end
  endtask

  task automatic test_bypass_split;
    wr(5'd12, 32'h100);
    @(negedge clk);
    bus.regwriteW = 1'b1;
    bus.memtoregW = 1'b0;
    bus.writeregW = 5'd12;
    bus.aluoutW   = 32'h200;
    bus.ra1D      = 5'd12;
    bus.ra2D      = 5'd10;
    #1;
    total++;
    if (bus.rd1D !== 32'h200 || bus.rd2D !== 32'h3) begin
      bad++;
      $display("FAIL bypass_split rd1=%h rd2=%h exp=200/3", bus.rd1D, bus.rd2D);
    end
    @(posedge clk);
    #1 bus.regwriteW = 1'b0;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    bus.regwriteW = 1'b0;
    bus.memtoregW = 1'b0;
    bus.writeregW = '0;
    bus.aluoutW   = '0;
    bus.readdataW = '0;
    bus.ra1D      = '0;
    bus.ra2D      = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    test_reset();
    test_write_read();
    test_load_path();
    test_r0();
    test_dual_port();
    test_reset_beats_write();
    test_back_to_back();
    test_bypass_split();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
